// File: rtl/usb_sie_rx_if.sv
// usb_sie_rx_if: UTMI receive byte stream from the UTM to the SIE receive decoder.
//   rx_active : receive in progress (SYNC seen until EOP)
//   rx_valid  : rx_data carries a valid byte this cycle
//   rx_error  : bit-stuff, EOP or alignment error reported by the UTM
//   rx_data   : received byte, LSB first on the wire
// master = UTM side (drives the stream), slave = SIE side (consumes it).
interface usb_sie_rx_if;
    logic       rx_active;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] rx_data;

    modport master (output rx_active, output rx_valid, output rx_error, output rx_data);
    modport slave  (input  rx_active, input  rx_valid, input  rx_error, input  rx_data);
endinterface

// File: rtl/usb_sie_rx.sv
// usb_sie_rx: receive-side packet decoder of the USB FS Serial Interface Engine.
// Consumes the UTMI receive byte stream, checks the PID, extracts token and SOF
// fields, checks CRC5/CRC16, strips the CRC bytes from data payloads and issues
// one end-of-packet status pulse per packet.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   utmi              UTMI receive stream (slave modport)
//   pid               PID[3:0] of the current/last packet
//   addr, endp        token address / endpoint
//   frame_num         SOF frame number
//   tok_valid         pulse: good IN/OUT/SETUP token
//   sof_valid         pulse: good SOF
//   hs_valid          pulse: good ACK/NAK/STALL
//   pl_data, pl_valid payload byte stream (CRC bytes never forwarded)
//   pkt_end, pkt_ok   end-of-packet pulse and its "fully valid" qualifier
//   err_pid, err_crc, err_len, err_rx   per-packet sticky error flags
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for rx_active to rise
// S_PID   | packet open, waiting for the PID byte
// S_TOK   | collecting the two token/SOF bytes, CRC5 running
// S_DATA  | collecting payload + CRC16 bytes, 2-byte delay line
// S_EXTRA | packet body complete; any further byte is a length error
module usb_sie_rx #(
    parameter int MAX_DATA_LEN = 1023
) (
    input  logic         clk,
    input  logic         rst,
    usb_sie_rx_if.slave  utmi,
    output logic [3:0]   pid,
    output logic [6:0]   addr,
    output logic [3:0]   endp,
    output logic [10:0]  frame_num,
    output logic         tok_valid,
    output logic         sof_valid,
    output logic         hs_valid,
    output logic [7:0]   pl_data,
    output logic         pl_valid,
    output logic         pkt_end,
    output logic         pkt_ok,
    output logic         err_pid,
    output logic         err_crc,
    output logic         err_len,
    output logic         err_rx
);

    localparam int              CW      = $clog2(MAX_DATA_LEN + 4);
    localparam logic [CW-1:0]   CNT_LIM = CW'(MAX_DATA_LEN + 2);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [4:0]  CRC5_RES  = 5'b01100;
    localparam logic [15:0] CRC16_RES = 16'h800D;

    typedef enum logic [2:0] {S_IDLE, S_PID, S_TOK, S_DATA, S_EXTRA} state_t;

    state_t          st, st_nxt;
    logic            act_d;
    logic [CW-1:0]   cnt;
    logic [4:0]      crc5;
    logic [15:0]     crc16;
    logic [7:0]      b1;
    logic [7:0]      d0, d1;

    logic            rise, acc, pid_byte, eop, in_pkt;
    logic            pid_bad, len_bad, crc16_bad, eop_ok;
    logic [4:0]      crc5_nxt;
    logic [15:0]     crc16_nxt;

    function automatic logic is_tok(input logic [3:0] p);
        return (p == PID_OUT) || (p == PID_IN) || (p == PID_SETUP);
    endfunction

    function automatic logic is_data(input logic [3:0] p);
        return (p == PID_DATA0) || (p == PID_DATA1);
    endfunction

    function automatic logic is_hs(input logic [3:0] p);
        return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL);
    endfunction

    function automatic state_t pid_next(input logic [3:0] p, input logic bad);
        if (bad)
            return S_EXTRA;
        else if (is_tok(p) || (p == PID_SOF))
            return S_TOK;
        else if (is_data(p))
            return S_DATA;
        else
            return S_EXTRA;
    endfunction

    // Serial CRCs with the register MSB aligned to the polynomial top term;
    // bits are fed LSB first, matching wire order.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ r[4])
                r = {r[3:0], 1'b0} ^ 5'h05;
            else
                r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ r[15])
                r = {r[14:0], 1'b0} ^ 16'h8005;
            else
                r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign rise     = utmi.rx_active & ~act_d;
    assign acc      = utmi.rx_valid & utmi.rx_active;
    // A PID byte arriving in the same cycle as the rx_active rise is still decoded.
    assign pid_byte = acc && ((st == S_PID) || ((st == S_IDLE) && rise));
    assign eop      = (st != S_IDLE) && !utmi.rx_active;
    assign in_pkt   = (st != S_IDLE) || rise;

    assign crc5_nxt  = crc5_byte(crc5, utmi.rx_data);
    assign crc16_nxt = crc16_byte(crc16, utmi.rx_data);

    always_ff @(posedge clk) begin
        if (rst)
            st <= S_IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt    = st;
        pid_bad   = (utmi.rx_data[7:4] != ~utmi.rx_data[3:0]) ||
                    !(is_tok(utmi.rx_data[3:0]) || (utmi.rx_data[3:0] == PID_SOF) ||
                      is_data(utmi.rx_data[3:0]) || is_hs(utmi.rx_data[3:0]));
        len_bad   = 1'b0;
        crc16_bad = 1'b0;

        case (st)
            S_IDLE: begin
                if (rise)
                    st_nxt = pid_byte ? pid_next(utmi.rx_data[3:0], pid_bad) : S_PID;
            end
            S_PID: begin
                len_bad = 1'b1;
                if (!utmi.rx_active)
                    st_nxt = S_IDLE;
                else if (acc)
                    st_nxt = pid_next(utmi.rx_data[3:0], pid_bad);
            end
            S_TOK: begin
                len_bad = 1'b1;
                if (!utmi.rx_active)
                    st_nxt = S_IDLE;
                else if (acc && (cnt == CW'(1)))
                    st_nxt = S_EXTRA;
            end
            S_DATA: begin
                len_bad   = (cnt < CW'(2));
                crc16_bad = (cnt >= CW'(2)) && (crc16 != CRC16_RES);
                if (!utmi.rx_active)
                    st_nxt = S_IDLE;
            end
            S_EXTRA: begin
                if (!utmi.rx_active)
                    st_nxt = S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase

        eop_ok = !(err_pid || err_crc || err_len || err_rx || len_bad || crc16_bad ||
                   utmi.rx_error);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // act_d resets high so a packet already in flight at reset release is ignored.
            act_d     <= 1'b1;
            cnt       <= '0;
            crc5      <= 5'h1F;
            crc16     <= 16'hFFFF;
            b1        <= '0;
            d0        <= '0;
            d1        <= '0;
            pid       <= '0;
            addr      <= '0;
            endp      <= '0;
            frame_num <= '0;
            tok_valid <= 1'b0;
            sof_valid <= 1'b0;
            hs_valid  <= 1'b0;
            pl_data   <= '0;
            pl_valid  <= 1'b0;
            pkt_end   <= 1'b0;
            pkt_ok    <= 1'b0;
            err_pid   <= 1'b0;
            err_crc   <= 1'b0;
            err_len   <= 1'b0;
            err_rx    <= 1'b0;
        end else begin
            act_d     <= utmi.rx_active;
            tok_valid <= 1'b0;
            sof_valid <= 1'b0;
            hs_valid  <= 1'b0;
            pl_valid  <= 1'b0;
            pkt_end   <= 1'b0;
            pkt_ok    <= 1'b0;

            if (rise) begin
                err_pid <= 1'b0;
                err_crc <= 1'b0;
                err_len <= 1'b0;
                err_rx  <= 1'b0;
            end

            if (pid_byte) begin
                pid     <= utmi.rx_data[3:0];
                err_pid <= pid_bad;
                cnt     <= '0;
                crc5    <= 5'h1F;
                crc16   <= 16'hFFFF;
            end

            if (acc && (st == S_TOK)) begin
                crc5 <= crc5_nxt;
                cnt  <= cnt + CW'(1);
                if (cnt == '0) begin
                    b1 <= utmi.rx_data;
                end else begin
                    if (is_tok(pid)) begin
                        addr <= b1[6:0];
                        endp <= {utmi.rx_data[2:0], b1[7]};
                    end else begin
                        frame_num <= {utmi.rx_data[2:0], b1};
                    end
                    if (crc5_nxt != CRC5_RES)
                        err_crc <= 1'b1;
                end
            end

            if (acc && (st == S_DATA)) begin
                crc16 <= crc16_nxt;
                if (cnt <= CNT_LIM)
                    cnt <= cnt + CW'(1);
                if (cnt >= CNT_LIM) begin
                    // Overlong packet: CRC keeps running but the byte is dropped.
                    err_len <= 1'b1;
                end else begin
                    d0 <= utmi.rx_data;
                    d1 <= d0;
                    if (cnt >= CW'(2)) begin
                        pl_data  <= d1;
                        pl_valid <= 1'b1;
                    end
                end
            end

            if (acc && (st == S_EXTRA))
                err_len <= 1'b1;

            if (eop) begin
                pkt_end   <= 1'b1;
                pkt_ok    <= eop_ok;
                tok_valid <= eop_ok && is_tok(pid);
                sof_valid <= eop_ok && (pid == PID_SOF);
                hs_valid  <= eop_ok && is_hs(pid);
                if (len_bad)
                    err_len <= 1'b1;
                if (crc16_bad)
                    err_crc <= 1'b1;
            end

            if (utmi.rx_error && in_pkt)
                err_rx <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usb_sie_rx.sv
module tb_usb_sie_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame_num;
    logic        tok_valid, sof_valid, hs_valid;
    logic [7:0]  pl_data;
    logic        pl_valid, pkt_end, pkt_ok;
    logic        err_pid, err_crc, err_len, err_rx;
    logic [44:0] all_out;

    int vectors = 0;
    int miscompares = 0;

    usb_sie_rx_if utmi();

    usb_sie_rx #(.MAX_DATA_LEN(1023)) dut (
        .clk       (clk),
        .rst       (rst),
        .utmi      (utmi),
        .pid       (pid),
        .addr      (addr),
        .endp      (endp),
        .frame_num (frame_num),
        .tok_valid (tok_valid),
        .sof_valid (sof_valid),
        .hs_valid  (hs_valid),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pkt_end   (pkt_end),
        .pkt_ok    (pkt_ok),
        .err_pid   (err_pid),
        .err_crc   (err_crc),
        .err_len   (err_len),
        .err_rx    (err_rx)
    );

    always #5 clk = ~clk;

    assign all_out = {pid, addr, endp, frame_num, tok_valid, sof_valid, hs_valid,
                      pl_data, pl_valid, pkt_end, pkt_ok, err_pid, err_crc, err_len, err_rx};

    // Pulse monitor, sampled on the inactive edge.
    int         n_end = 0, n_tok = 0, n_sof = 0, n_hs = 0;
    logic       last_ok = 1'b0;
    logic [7:0] pl_q[$];

    always @(negedge clk) begin
        if (pkt_end) begin
            n_end++;
            last_ok = pkt_ok;
        end
        if (tok_valid) n_tok++;
        if (sof_valid) n_sof++;
        if (hs_valid)  n_hs++;
        if (pl_valid)  pl_q.push_back(pl_data);
    end

    int e0, t0, s0, h0, q0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) cyc();
        utmi.rx_data  = b;
        utmi.rx_valid = 1'b1;
        cyc();
        utmi.rx_valid = 1'b0;
    endtask

    task automatic begin_pkt();
        e0 = n_end;
        t0 = n_tok;
        s0 = n_sof;
        h0 = n_hs;
        q0 = pl_q.size();
        utmi.rx_active = 1'b1;
        cyc();
    endtask

    task automatic end_pkt(input string tag, input int exp_ends);
        utmi.rx_active = 1'b0;
        repeat (3) cyc();
        chk({tag, "_pkt_end_count"}, 64'(n_end - e0), 64'(exp_ends));
        repeat (2) cyc();
    endtask

    // Reference CRCs in reflected form; returned values are the transmitted (complemented) fields.
    function automatic logic [4:0] ref_crc5(input logic [10:0] v);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (c[0] ^ v[i]) c = (c >> 1) ^ 5'h14;
            else             c = c >> 1;
        end
        return ~c;
    endfunction

    function automatic logic [15:0] ref_crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic send_token(input logic [7:0] pidb, input logic [10:0] v);
        logic [4:0] c;
        c = ref_crc5(v);
        send(pidb, 1);
        send(v[7:0], 0);
        send({c, v[10:8]}, 0);
    endtask

    task automatic send_data(input logic [7:0] pidb, input logic [7:0] pl[$], input int gap,
                             input int flip_idx);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        foreach (pl[i]) c = ref_crc16_upd(c, pl[i]);
        c = ~c;
        send(pidb, gap);
        foreach (pl[i]) begin
            b = pl[i];
            if (i == flip_idx) b = b ^ 8'h01;
            send(b, gap);
        end
        send(c[7:0], gap);
        send(c[15:8], gap);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pay[$];
        logic       pl_match;

        utmi.rx_active = 1'b0;
        utmi.rx_valid  = 1'b0;
        utmi.rx_error  = 1'b0;
        utmi.rx_data   = 8'h00;
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset_outputs", 64'(all_out), 64'd0);
        rst = 1'b0;
        repeat (3) cyc();

        // ACK handshake
        begin_pkt();
        send(8'hD2, 1);
        end_pkt("ack", 1);
        chk("ack_pid", 64'(pid), 64'h2);
        chk("ack_ok", 64'(last_ok), 64'd1);
        chk("ack_hs_valid", 64'(n_hs - h0), 64'd1);
        chk("ack_no_payload", 64'(pl_q.size() - q0), 64'd0);

        // SETUP addr 0 endp 0
        begin_pkt();
        send(8'h2D, 1);
        send(8'h00, 0);
        send(8'h10, 0);
        end_pkt("setup", 1);
        chk("setup_tok_valid", 64'(n_tok - t0), 64'd1);
        chk("setup_addr", 64'(addr), 64'd0);
        chk("setup_endp", 64'(endp), 64'd0);
        chk("setup_ok", 64'(last_ok), 64'd1);

        // SETUP with corrupted CRC5 field
        begin_pkt();
        send(8'h2D, 1);
        send(8'h00, 0);
        send(8'h18, 0);
        end_pkt("setup_badcrc", 1);
        chk("setup_badcrc_err_crc", 64'(err_crc), 64'd1);
        chk("setup_badcrc_tok_valid", 64'(n_tok - t0), 64'd0);
        chk("setup_badcrc_ok", 64'(last_ok), 64'd0);

        // OUT token addr 0x15 endp 0xA
        begin_pkt();
        send_token(8'hE1, {4'hA, 7'h15});
        end_pkt("out", 1);
        chk("out_tok_valid", 64'(n_tok - t0), 64'd1);
        chk("out_addr", 64'(addr), 64'h15);
        chk("out_endp", 64'(endp), 64'hA);
        chk("out_pid", 64'(pid), 64'h1);

        // SOF frame 0x5A3
        begin_pkt();
        send_token(8'hA5, 11'h5A3);
        end_pkt("sof", 1);
        chk("sof_valid", 64'(n_sof - s0), 64'd1);
        chk("sof_frame", 64'(frame_num), 64'h5A3);
        chk("sof_addr_held", 64'(addr), 64'h15);

        // zero-length DATA0
        begin_pkt();
        send(8'hC3, 1);
        send(8'h00, 0);
        send(8'h00, 0);
        end_pkt("zlp", 1);
        chk("zlp_ok", 64'(last_ok), 64'd1);
        chk("zlp_no_payload", 64'(pl_q.size() - q0), 64'd0);

        // DATA1 with 8 bytes
        pay = '{8'h3A, 8'hC5, 8'h01, 8'hFF, 8'h7E, 8'h80, 8'h5B, 8'h96};
        begin_pkt();
        send_data(8'h4B, pay, 0, -1);
        end_pkt("data1", 1);
        chk("data1_ok", 64'(last_ok), 64'd1);
        chk("data1_count", 64'(pl_q.size() - q0), 64'd8);
        pl_match = 1'b1;
        for (int i = 0; i < 8; i++)
            if ((q0 + i >= pl_q.size()) || (pl_q[q0 + i] !== pay[i])) pl_match = 1'b0;
        chk("data1_bytes", 64'(pl_match), 64'd1);

        // same packet with one payload bit flipped
        begin_pkt();
        send_data(8'h4B, pay, 0, 3);
        end_pkt("data1_flip", 1);
        chk("data1_flip_err_crc", 64'(err_crc), 64'd1);
        chk("data1_flip_ok", 64'(last_ok), 64'd0);

        // bad PID check nibble
        begin_pkt();
        send(8'hD3, 1);
        end_pkt("badpid", 1);
        chk("badpid_err_pid", 64'(err_pid), 64'd1);
        chk("badpid_ok", 64'(last_ok), 64'd0);

        // token with an extra 4th byte
        begin_pkt();
        send(8'h2D, 1);
        send(8'h00, 0);
        send(8'h10, 0);
        send(8'h55, 0);
        end_pkt("tok4", 1);
        chk("tok4_err_len", 64'(err_len), 64'd1);
        chk("tok4_tok_valid", 64'(n_tok - t0), 64'd0);
        chk("tok4_ok", 64'(last_ok), 64'd0);

        // rx_error during a sparse DATA0
        begin_pkt();
        send(8'hC3, 7);
        send(8'h11, 7);
        send(8'h22, 7);
        utmi.rx_error = 1'b1;
        cyc();
        utmi.rx_error = 1'b0;
        send(8'h33, 7);
        send(8'h44, 7);
        send(8'h55, 7);
        end_pkt("rxerr", 1);
        chk("rxerr_err_rx", 64'(err_rx), 64'd1);
        chk("rxerr_ok", 64'(last_ok), 64'd0);

        // rx_active drops before any PID byte
        begin_pkt();
        end_pkt("nopid", 1);
        chk("nopid_err_len", 64'(err_len), 64'd1);
        chk("nopid_ok", 64'(last_ok), 64'd0);

        // DATA0 with only one byte after the PID
        begin_pkt();
        send(8'hC3, 1);
        send(8'h00, 0);
        end_pkt("short", 1);
        chk("short_err_len", 64'(err_len), 64'd1);
        chk("short_no_payload", 64'(pl_q.size() - q0), 64'd0);
        chk("short_ok", 64'(last_ok), 64'd0);

        // reset in the middle of a token
        begin_pkt();
        send(8'h2D, 1);
        send(8'h00, 0);
        rst = 1'b1;
        cyc();
        chk("midreset_outputs", 64'(all_out), 64'd0);
        cyc();
        rst = 1'b0;
        send(8'h10, 0);
        end_pkt("midreset", 0);

        // next ACK still decodes
        begin_pkt();
        send(8'hD2, 2);
        end_pkt("ack2", 1);
        chk("ack2_hs_valid", 64'(n_hs - h0), 64'd1);
        chk("ack2_ok", 64'(last_ok), 64'd1);
        chk("ack2_pid", 64'(pid), 64'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
